// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single write port of an 8 x 16-bit register file between two
// writeback requesters (req0 = ALU, req1 = load/memory) using round-robin
// arbitration. The accepted write is registered once and presented to the
// file as regWrite, a one-hot decOut and writeData one cycle after the grant.
//
// Optional build macro: RF_ARB_STATS_EN adds saturating 16-bit grant and
// conflict counters (gnt_cnt0, gnt_cnt1, conflict_cnt).
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   stall         1 = no grants this cycle
//   req0/addr0/data0, gnt0   requester 0 request, destination, data, grant
//   req1/addr1/data1, gnt1   requester 1 request, destination, data, grant
//   regWrite      registered register-file write enable
//   decOut        registered one-hot register select (zero when no write)
//   writeData     registered write data (holds when no write)
//   gnt_cnt0/gnt_cnt1/conflict_cnt  statistics (RF_ARB_STATS_EN only)

module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic              regWrite,
    output logic [(2**ADDR_W)-1:0] decOut,
    output logic [DATA_W-1:0] writeData
`ifdef RF_ARB_STATS_EN
    ,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    typedef enum logic {StPri0, StPri1} pri_e;

    pri_e              pri_q, pri_d;
    logic              regwrite_q, regwrite_d;
    logic [NREGS-1:0]  decout_q, decout_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;

    // Grant and priority next-state. Reset and stall suppress every grant.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        pri_d = pri_q;
        if (!reset && !stall) begin
            if (req0 && req1) begin
                gnt0 = (pri_q == StPri0);
                gnt1 = (pri_q == StPri1);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        // Every grant hands priority to the other requester.
        if (gnt0) begin
            pri_d = StPri1;
        end else if (gnt1) begin
            pri_d = StPri0;
        end
    end

    // Write-port next-state: decOut is cleared on idle cycles, data holds.
    always_comb begin
        regwrite_d  = gnt0 | gnt1;
        decout_d    = '0;
        writedata_d = writedata_q;
        if (gnt0) begin
            decout_d[addr0] = 1'b1;
            writedata_d     = data0;
        end else if (gnt1) begin
            decout_d[addr1] = 1'b1;
            writedata_d     = data1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pri_q       <= StPri0;
            regwrite_q  <= 1'b0;
            decout_q    <= '0;
            writedata_q <= '0;
        end else begin
            pri_q       <= pri_d;
            regwrite_q  <= regwrite_d;
            decout_q    <= decout_d;
            writedata_q <= writedata_d;
        end
    end

    assign regWrite  = regwrite_q;
    assign decOut    = decout_q;
    assign writeData = writedata_q;

`ifdef RF_ARB_STATS_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [15:0] gnt_cnt1_q, gnt_cnt1_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic        conflict;

    // A conflict is a contended cycle that could have granted; reset wins.
    assign conflict = req0 & req1 & ~stall;

    always_comb begin
        gnt_cnt0_d     = gnt_cnt0_q;
        gnt_cnt1_d     = gnt_cnt1_q;
        conflict_cnt_d = conflict_cnt_q;
        if (gnt0 && gnt_cnt0_q != 16'hFFFF) begin
            gnt_cnt0_d = gnt_cnt0_q + 16'd1;
        end
        if (gnt1 && gnt_cnt1_q != 16'hFFFF) begin
            gnt_cnt1_d = gnt_cnt1_q + 16'd1;
        end
        if (conflict && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0_q     <= '0;
            gnt_cnt1_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            gnt_cnt0_q     <= gnt_cnt0_d;
            gnt_cnt1_q     <= gnt_cnt1_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign gnt_cnt0     = gnt_cnt0_q;
    assign gnt_cnt1     = gnt_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset, stall, req0, req1;
    logic [2:0]  addr0, addr1;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1, regWrite;
    logic [7:0]  decOut;
    logic [15:0] writeData;
`ifdef RF_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: who is favoured next, the visible write, counters.
    int          pref;
    bit          m_we;
    logic [7:0]  m_dec;
    logic [15:0] m_wd;
    int          m_g0, m_g1, m_cf;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req0      (req0),
        .addr0     (addr0),
        .data0     (data0),
        .gnt0      (gnt0),
        .req1      (req1),
        .addr1     (addr1),
        .data1     (data1),
        .gnt1      (gnt1),
        .regWrite  (regWrite),
        .decOut    (decOut),
        .writeData (writeData)
`ifdef RF_ARB_STATS_EN
        ,
        .gnt_cnt0     (gnt_cnt0),
        .gnt_cnt1     (gnt_cnt1),
        .conflict_cnt (conflict_cnt)
`endif
    );

    function automatic void model_gnt(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset && !stall) begin
            if (req0 && req1) begin
                g0 = (pref == 0);
                g1 = (pref == 1);
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
    endfunction

    task automatic model_edge();
        bit g0, g1;
        model_gnt(g0, g1);
        if (reset) begin
            pref = 0; m_we = 1'b0; m_dec = 8'h00; m_wd = 16'h0000;
            m_g0 = 0; m_g1 = 0; m_cf = 0;
        end else begin
            m_we  = g0 | g1;
            m_dec = 8'h00;
            if (g0) begin m_dec[addr0] = 1'b1; m_wd = data0; pref = 1; end
            if (g1) begin m_dec[addr1] = 1'b1; m_wd = data1; pref = 0; end
            if (g0 && m_g0 < 65535) m_g0++;
            if (g1 && m_g1 < 65535) m_g1++;
            if (req0 && req1 && !stall && m_cf < 65535) m_cf++;
        end
    endtask

    // Advance one clock: model follows the same edge, inputs change 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0;
        req0 = 1'b1; addr0 = 3'd3; data0 = 16'h3333;
        req1 = 1'b1; addr1 = 3'd4; data1 = 16'h4444;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({gnt0, gnt1} !== 2'b00) begin
                errors++; $display("FAIL reset_gnt got %b want 00", {gnt0, gnt1});
            end
            tick();
            checks++;
            if ({regWrite, decOut, writeData} !== {1'b0, 8'h00, 16'h0000}) begin
                errors++;
                $display("FAIL reset_out got we=%b dec=%h wd=%h want 0/00/0000",
                         regWrite, decOut, writeData);
            end
        end
        req0 = 1'b0; req1 = 1'b0; reset = 1'b0;
    endtask

    task automatic test_single();
        req0 = 1'b1; addr0 = 3'd5; data0 = 16'hA5A5;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL single_gnt got %b want 10", {gnt0, gnt1});
        end
        tick();
        req0 = 1'b0;
        checks++;
        if ({regWrite, decOut, writeData} !== {1'b1, 8'h20, 16'hA5A5}) begin
            errors++;
            $display("FAIL single_write got we=%b dec=%h wd=%h want 1/20/a5a5",
                     regWrite, decOut, writeData);
        end
        tick();
        checks++;
        if ({regWrite, decOut, writeData} !== {1'b0, 8'h00, 16'hA5A5}) begin
            errors++;
            $display("FAIL single_idle got we=%b dec=%h wd=%h want 0/00/a5a5",
                     regWrite, decOut, writeData);
        end
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1'b1; addr0 = 3'd1; data0 = 16'h1111;
        req1 = 1'b1; addr1 = 3'd2; data1 = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  exp_g;
            logic [24:0] exp_o;
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_o = (i % 2 == 0) ? {1'b1, 8'h02, 16'h1111} : {1'b1, 8'h04, 16'h2222};
            #1;
            checks++;
            if ({gnt0, gnt1} !== exp_g) begin
                errors++; $display("FAIL rr_gnt[%0d] got %b want %b", i, {gnt0, gnt1}, exp_g);
            end
            tick();
            checks++;
            if ({regWrite, decOut, writeData} !== exp_o) begin
                errors++;
                $display("FAIL rr_write[%0d] got %h want %h", i,
                         {regWrite, decOut, writeData}, exp_o);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        stall = 1'b1; req0 = 1'b1; addr0 = 3'd6; data0 = 16'h6666;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({gnt0, gnt1} !== 2'b00) begin
                errors++; $display("FAIL stall_gnt[%0d] got %b want 00", i, {gnt0, gnt1});
            end
            tick();
            checks++;
            if (regWrite !== 1'b0) begin
                errors++; $display("FAIL stall_we[%0d] got %b want 0", i, regWrite);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL unstall_gnt got %b want 10", {gnt0, gnt1});
        end
        tick();
        req0 = 1'b0;
        checks++;
        if ({regWrite, decOut, writeData} !== {1'b1, 8'h40, 16'h6666}) begin
            errors++;
            $display("FAIL unstall_write got %h want %h",
                     {regWrite, decOut, writeData}, {1'b1, 8'h40, 16'h6666});
        end
    endtask

    task automatic test_reset_after_grant();
        req1 = 1'b1; addr1 = 3'd7; data1 = 16'hBEEF;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++; $display("FAIL rag_gnt got %b want 01", {gnt0, gnt1});
        end
        tick();
        reset = 1'b1;
        req0 = 1'b1; addr0 = 3'd0; data0 = 16'h0F0F;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++; $display("FAIL rag_reset_gnt got %b want 00", {gnt0, gnt1});
        end
        tick();
        reset = 1'b0;
        checks++;
        if ({regWrite, decOut, writeData} !== {1'b0, 8'h00, 16'h0000}) begin
            errors++;
            $display("FAIL rag_after_reset got we=%b dec=%h wd=%h want 0/00/0000",
                     regWrite, decOut, writeData);
        end
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL rag_conflict_gnt got %b want 10", {gnt0, gnt1});
        end
        tick();
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if ({regWrite, decOut, writeData} !== {1'b1, 8'h01, 16'h0F0F}) begin
            errors++;
            $display("FAIL rag_conflict_write got %h want %h",
                     {regWrite, decOut, writeData}, {1'b1, 8'h01, 16'h0F0F});
        end
    endtask

`ifdef RF_ARB_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if ({gnt_cnt0, gnt_cnt1, conflict_cnt} !== {16'd2, 16'd2, 16'd4}) begin
            errors++;
            $display("FAIL stats_count got %0d/%0d/%0d want 2/2/4",
                     gnt_cnt0, gnt_cnt1, conflict_cnt);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({gnt_cnt0, gnt_cnt1, conflict_cnt} !== 48'd0) begin
            errors++;
            $display("FAIL stats_clear got %0d/%0d/%0d want 0/0/0",
                     gnt_cnt0, gnt_cnt1, conflict_cnt);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit g0, g1;
            reset = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 3) == 0);
            if (!req0) begin
                if ($urandom_range(0, 2) != 0) begin
                    req0 = 1'b1; addr0 = 3'($urandom); data0 = 16'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                req0 = 1'b0;
            end
            if (!req1) begin
                if ($urandom_range(0, 2) != 0) begin
                    req1 = 1'b1; addr1 = 3'($urandom); data1 = 16'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                req1 = 1'b0;
            end
            #1;
            model_gnt(g0, g1);
            checks++;
            if ({gnt0, gnt1} !== {g0, g1}) begin
                errors++; $display("FAIL rand_gnt[%0d] got %b want %b", i, {gnt0, gnt1}, {g0, g1});
            end
            tick();
            if (g0) req0 = 1'b0;
            if (g1) req1 = 1'b0;
            checks++;
            if ({regWrite, decOut, writeData} !== {m_we, m_dec, m_wd}) begin
                errors++;
                $display("FAIL rand_write[%0d] got we=%b dec=%h wd=%h want %b/%h/%h", i,
                         regWrite, decOut, writeData, m_we, m_dec, m_wd);
            end
`ifdef RF_ARB_STATS_EN
            checks++;
            if ({gnt_cnt0, gnt_cnt1, conflict_cnt} !== {16'(m_g0), 16'(m_g1), 16'(m_cf)}) begin
                errors++;
                $display("FAIL rand_stats[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         gnt_cnt0, gnt_cnt1, conflict_cnt, m_g0, m_g1, m_cf);
            end
`endif
        end
        reset = 1'b0; stall = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0;
        req0 = 1'b0; addr0 = '0; data0 = '0;
        req1 = 1'b0; addr1 = '0; data1 = '0;
        pref = 0; m_we = 1'b0; m_dec = '0; m_wd = '0;
        m_g0 = 0; m_g1 = 0; m_cf = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_after_grant();
`ifdef RF_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
